// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular FIFO of {pc, instr} between fetch and decode,
// with single-cycle flush on mispredict. Optional bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  input  logic                     mispredict,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count_q;
  logic          bypass;
  logic          push;
  logic          pop;

  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    bypass = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue with a ready consumer: hand the fetch entry straight to decode.
    bypass = empty && in_valid && out_ready && !mispredict;
`else
    bypass = 1'b0;
`endif
    in_ready  = !full && !mispredict;
    out_valid = (!empty || bypass) && !mispredict;
    out_pc    = mem_pc[head];
    out_instr = mem_instr[head];
    if (bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end
    push = in_valid && in_ready && !bypass;
    pop  = !empty && out_ready && !mispredict;
  end

  always_ff @(posedge clk) begin
    if (reset || mispredict) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage is never cleared; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[tail]    <= in_pc;
      mem_instr[tail] <= in_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: driver queues expected entries, a negedge
// monitor pops and compares whatever the queue hands to decode.
module tb_fetch_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        mispredict;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  int total = 0;
  int bad   = 0;
  int model_cnt = 0;
  logic [63:0] sb [$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .mispredict(mispredict), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; expectations come from the bench's own occupancy model.
  task automatic cyc(input logic iv, input logic [31:0] pc, input logic ordy,
                     input logic mp, input logic rst);
    logic exp_rdy, byp, push_ok, pop_ok;
    reset = rst; in_valid = iv; in_pc = pc; in_instr = pc + 32'h1000;
    out_ready = ordy; mispredict = mp;
    exp_rdy = (model_cnt != DEPTH) && !mp;
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (model_cnt == 0) && iv && ordy && !mp;
`endif
    push_ok = iv && exp_rdy && !rst;
    pop_ok  = (model_cnt != 0) && ordy && !mp && !rst;
    if (rst || mp) sb.delete();
    else if (push_ok) sb.push_back({pc, pc + 32'h1000});
    #1;
    if (!rst) begin
      chk("in_ready",  64'(in_ready),  64'(exp_rdy));
      chk("out_valid", 64'(out_valid), 64'(((model_cnt != 0) || byp) && !mp));
      chk("count",     64'(count),     64'(model_cnt));
      chk("full",      64'(full),      64'(model_cnt == DEPTH));
      chk("empty",     64'(empty),     64'(model_cnt == 0));
    end
    if (rst || mp) model_cnt = 0;
    else model_cnt = model_cnt + ((push_ok && !byp) ? 1 : 0) - (pop_ok ? 1 : 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out got=%h want=none t=%0t", {out_pc, out_instr}, $time);
      end else begin
        chk("out_entry", {out_pc, out_instr}, sb.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    out_ready = 1'b0; mispredict = 1'b0;
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);

    // Fill to full, offer a ninth entry, then drain in order.
    for (int i = 0; i < 8; i++) cyc(1, 32'(i * 4), 0, 0, 0);
    cyc(1, 32'h20, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Streaming: simultaneous push and pop for 20 cycles, pointers wrap.
    for (int i = 0; i < 20; i++) cyc(1, 32'h200 + 32'(i * 4), 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Flush with five queued while pc 0x40 is offered.
    for (int i = 0; i < 5; i++) cyc(1, 32'h300 + 32'(i * 4), 0, 0, 0);
    cyc(1, 32'h40, 1, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 32'h50, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Push and pop together at count 3, then drain.
    for (int i = 0; i < 3; i++) cyc(1, 32'h60 + 32'(i * 4), 0, 0, 0);
    cyc(1, 32'h80, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Empty queue, offer and consume same cycle (bypass when compiled in).
    cyc(1, 32'h100, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Reset mid-operation with entries queued.
    cyc(1, 32'h400, 0, 0, 0);
    cyc(1, 32'h404, 0, 0, 0);
    cyc(1, 32'h408, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 32'h500, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);

    chk("sb_leftover", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the instruction-memory fetch port and the decode stage of the frontend. It buffers fetched {pc, instr} pairs in a circular FIFO and decouples fetch from decode/rename back-pressure. On a branch mispredict it discards all wrong-path entries in one cycle, so decode sees only post-redirect instructions.

## Interface

- DEPTH, 8, number of entries; power of two, at least 2
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  fetch offers an entry this cycle
- in_ready  output  1  queue accepts an entry this cycle
- in_pc  input  32  PC of the offered instruction
- in_instr  input  32  instruction word of the offered entry
- out_valid  output  1  head entry is presented to decode
- out_ready  input  1  decode consumes the head this cycle
- out_pc  output  32  PC of the head entry
- out_instr  output  32  instruction word of the head entry
- mispredict  input  1  global flush from the ROB; discards all entries
- count  output  $clog2(DEPTH)+1  current occupancy
- full  output  1  count == DEPTH
- empty  output  1  count == 0

## Operation

- Storage: DEPTH-entry array of {pc[31:0], instr[31:0]}, with head and tail pointers of width $clog2(DEPTH) and an occupancy counter.
- Push: in_valid && in_ready writes the entry at tail; tail increments modulo DEPTH.
- Pop: out_valid && out_ready increments head modulo DEPTH.
- in_ready = !full && !mispredict. A full queue never accepts a push, even when a pop happens in the same cycle.
- out_valid = !empty && !mispredict. out_pc and out_instr come from array[head]; their value is don't-care while out_valid is 0.
- Push and pop in the same cycle leave count unchanged; both pointers advance.
- Flush: when mispredict is 1, head, tail and count go to 0 at the next edge. Any push or pop offered in that cycle is ignored. Flush has priority over push and pop.
- Array contents are not cleared on reset or flush; only the pointers and counter reset.
- count, full and empty are registered-state derived and are not gated by mispredict.

## Timing

- Reset values: in_ready=1, out_valid=0, count=0, full=0, empty=1. out_pc and out_instr are don't-care.
- Reset applied mid-operation behaves identically to a flush plus clearing of all state. Reset has priority over mispredict.
- Latency: an entry pushed at edge N is visible as the head with out_valid=1 in cycle N+1. This is one cycle of latency; there is no same-cycle pass-through unless the Configuration option is compiled in.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- First cycle after a flush: the queue is empty, in_ready=1, out_valid=0.

## Configuration

- FETCH_QUEUE_BYPASS_EN defined: when empty && in_valid && out_ready && !mispredict, the input entry passes combinationally to out_pc/out_instr with out_valid=1 and is not written to the array. count stays 0, giving zero-cycle latency.
- If empty and out_ready=0, the input is stored normally.
- Undefined: no combinational path from the in_* inputs to the out_* outputs; latency is always one cycle.

## Test plan

- Reset held 2 cycles, then released -> in_ready=1, out_valid=0, count=0, empty=1.
- Push 8 entries (pc=0x00..0x1C, instr=pc+0x1000) with out_ready=0 -> full=1 and in_ready=0 after the 8th push. A 9th in_valid is ignored. Then drain with out_ready=1 -> pcs 0x00..0x1C in order, empty=1 afterwards.
- Hold in_valid=1 and out_ready=1 for 20 cycles -> count steady at 1 (0 with bypass), pointers wrap twice, out_pc increments by 4 each cycle with no gaps or duplicates.
- With 5 entries queued, assert mispredict for 1 cycle while pushing pc=0x40 -> out_valid=0 in the flush cycle, count=0 next cycle, and 0x40 never appears at the output.
- With 3 entries queued, push pc=0x80 and pop simultaneously -> count remains 3 and 0x80 emerges after the three older entries.
- FETCH_QUEUE_BYPASS_EN defined, queue empty, in_valid=1, in_pc=0x100, out_ready=1 -> same cycle out_valid=1, out_pc=0x100, and count stays 0 at the next edge.
